// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: stall FSM encoding,
// the hard-wired zero register, and the destination-match helper.
package hazard_pkg;

    // Stall FSM states. STALL2 is kept in the encoding for future 3-cycle hazards.
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        STALL1 = 2'b01,
        STALL2 = 2'b10
    } state_t;

    // Register $0 is hard-wired to zero, so writes to it never create a dependence.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a producer destination feeds rs, or rt when rt is actually read.
    function automatic logic dest_hits(
        input logic [4:0] dest,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       check_rt
    );
        return (dest != REG_ZERO) && ((dest == rs) || (check_rt && (dest == rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full = (r_count == {W{1'b1}});

    // Count qualifying cycles, stopping at the maximum value.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && !w_full) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the 5-stage MIPS core. Compares the ID-stage
// source registers against the EX and MEM destinations, stalls the front end
// (PC / IF-ID hold plus an ID bubble) for load-use and branch operand hazards,
// flushes IF on taken branches and jumps, and counts stall and flush cycles.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             branch_taken,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_reg_write,
    input  logic [4:0]       id_ex_dest,
    input  logic             ex_mem_mem_read,
    input  logic [4:0]       ex_mem_dest,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             Data_Hazard,
    output logic             IF_Flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    state_t r_state;
    state_t w_next_state;

    logic w_check_rt;
    logic w_match_ex;
    logic w_match_mem;
    logic w_in_run;
    logic w_need1;
    logic w_need2;
    logic w_stall;
    logic w_flush;

    // Branches compare both operands in ID, so rt matters for them even if not otherwise read.
    assign w_check_rt  = id_uses_rt | id_branch;
    assign w_match_ex  = dest_hits(id_ex_dest,  if_id_rs, if_id_rt, w_check_rt);
    assign w_match_mem = dest_hits(ex_mem_dest, if_id_rs, if_id_rt, w_check_rt);

    assign w_in_run = (r_state == RUN);

    // A branch needing a value still being loaded in EX waits two cycles.
    assign w_need2 = w_in_run & id_branch & id_ex_mem_read & w_match_ex;

    // Single-cycle stalls: classic load-use, or a branch waiting on an ALU
    // result in EX or a load result in MEM.
    assign w_need1 = w_in_run & ~w_need2 &
                     ((id_ex_mem_read & w_match_ex) |
                      (id_branch & id_ex_reg_write & w_match_ex) |
                      (id_branch & ex_mem_mem_read & w_match_mem));

    assign w_stall = ~w_in_run | w_need1 | w_need2;

    // Stall FSM state register; reset can land at any point, including mid-stall.
    // NOTE: state and counters reset asynchronously; there are no memories here to leave unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: a 2-cycle hazard parks in STALL1 for one extra cycle; anything else returns to RUN.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = RUN;
        case (r_state)
            RUN:     w_next_state = w_need2 ? STALL1 : RUN;
            STALL1:  w_next_state = RUN;
            STALL2:  w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
    end

    // Output decode: reset forces everything inactive, a stall beats a flush
    // (branch operands are not valid yet), otherwise the pipe advances.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        Data_Hazard = 1'b0;
        IF_Flush    = 1'b0;
        if (reset && !w_stall) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            Data_Hazard = 1'b1;
            IF_Flush    = id_jump | (id_branch & branch_taken);
        end
    end

    // Flush cycles are only those in which IF_Flush is actually driven high.
    assign w_flush = IF_Flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush),
        .count (flush_count)
    );

endmodule
